// File: rtl/alu_status_handler.sv
// Consumer of the ALU status bus: latches flags, accumulates sticky flags, evaluates branch
// conditions and raises a masked exception request with a req/ack handshake that stalls the datapath.
module alu_status_handler #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               status_valid,
  input  logic [7:0]         ALU_status,
  input  logic [2:0]         exc_mask,
  input  logic [2:0]         cond_sel,
  input  logic               sticky_clr,
  input  logic               exc_ack,
  output logic [7:0]         flags,
  output logic [7:0]         sticky,
  output logic               cond_true,
  output logic               exc_req,
  output logic [1:0]         exc_cause,
  output logic               stall,
  output logic [COUNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e             state_q, state_d;
  logic [1:0]         cause_q, cause_d;
  logic [7:0]         flags_q, flags_d;
  logic [7:0]         sticky_q, sticky_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic       sample;
  logic [7:0] status_bits;
  logic [1:0] event_cause;
  logic       unused_bits;

  assign unused_bits = ^ALU_status[1:0];

  assign stall       = (state_q != StIdle);
  assign sample      = status_valid & ~stall;
  assign status_bits = {ALU_status[7:2], 2'b00};

  // Zero cause means no enabled event; priority is div-by-zero, then overflow, then odd.
  always_comb begin
    event_cause = 2'd0;
    if (ALU_status[2] & exc_mask[2]) begin
      event_cause = 2'd3;
    end else if (ALU_status[6] & exc_mask[1]) begin
      event_cause = 2'd2;
    end else if (ALU_status[3] & exc_mask[0]) begin
      event_cause = 2'd1;
    end
  end

  // Clear is applied first so a coinciding sample starts the accumulation afresh.
  always_comb begin
    flags_d  = flags_q;
    sticky_d = sticky_clr ? 8'h00 : sticky_q;
    cnt_d    = sticky_clr ? '0 : cnt_q;
    if (sample) begin
      flags_d  = status_bits;
      sticky_d = sticky_d | status_bits;
      if (ALU_status[6] && !(&cnt_d)) begin
        cnt_d = cnt_d + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      StIdle: begin
        if (sample && (event_cause != 2'd0)) begin
          state_d = StReq;
          cause_d = event_cause;
        end
      end
      StReq: begin
        if (exc_ack) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StIdle;
        cause_d = 2'd0;
      end
      default: begin
        state_d = StIdle;
        cause_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cause_q  <= 2'd0;
      flags_q  <= 8'h00;
      sticky_q <= 8'h00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    case (cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flags_q[7];
      3'd2:    cond_true = ~flags_q[7];
      3'd3:    cond_true = flags_q[4] ^ flags_q[6];
      3'd4:    cond_true = ~(flags_q[4] ^ flags_q[6]);
      3'd5:    cond_true = flags_q[5];
      3'd6:    cond_true = flags_q[6];
      default: cond_true = 1'b0;
    endcase
  end

  assign flags     = flags_q;
  assign sticky    = sticky_q;
  assign exc_req   = (state_q == StReq);
  assign exc_cause = cause_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_status_handler.sv
// Directed-vector bench for alu_status_handler; a second instance with COUNT_W = 2 covers
// counter saturation.
module tb_alu_status_handler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       status_valid;
  logic [7:0] ALU_status;
  logic [2:0] exc_mask;
  logic [2:0] cond_sel;
  logic       sticky_clr;
  logic       exc_ack;

  logic [7:0] flags, sticky;
  logic       cond_true, exc_req, stall;
  logic [1:0] exc_cause;
  logic [7:0] ovf_count;

  logic [7:0] flags2, sticky2;
  logic       cond_true2, exc_req2, stall2;
  logic [1:0] exc_cause2;
  logic [1:0] ovf_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_status_handler #(.COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .status_valid(status_valid), .ALU_status(ALU_status),
    .exc_mask(exc_mask), .cond_sel(cond_sel), .sticky_clr(sticky_clr), .exc_ack(exc_ack),
    .flags(flags), .sticky(sticky), .cond_true(cond_true), .exc_req(exc_req),
    .exc_cause(exc_cause), .stall(stall), .ovf_count(ovf_count)
  );

  alu_status_handler #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .status_valid(status_valid), .ALU_status(ALU_status),
    .exc_mask(exc_mask), .cond_sel(cond_sel), .sticky_clr(sticky_clr), .exc_ack(exc_ack),
    .flags(flags2), .sticky(sticky2), .cond_true(cond_true2), .exc_req(exc_req2),
    .exc_cause(exc_cause2), .stall(stall2), .ovf_count(ovf_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    status_valid = 1'($urandom);
    ALU_status   = 8'($urandom);
    exc_mask     = 3'($urandom);
    cond_sel     = 3'($urandom);
    sticky_clr   = 1'($urandom);
    exc_ack      = 1'($urandom);
    step();
    ALU_status   = 8'($urandom);
    status_valid = 1'($urandom);
    step();
    check("rst_flags", flags, 0);
    check("rst_sticky", sticky, 0);
    check("rst_exc_req", exc_req, 0);
    check("rst_exc_cause", exc_cause, 0);
    check("rst_stall", stall, 0);
    check("rst_ovf_count", ovf_count, 0);
    check("rst_ovf_count2", ovf_count2, 0);

    rst_n = 1'b1; status_valid = 1'b0; exc_mask = 3'b000; sticky_clr = 1'b0; exc_ack = 1'b0;
    cond_sel = 3'd0;
    step();

    // Flag latch and branch conditions
    status_valid = 1'b1; ALU_status = 8'b1000_0000;
    step();
    status_valid = 1'b0; cond_sel = 3'd1; #1;
    check("flags_80", flags, 8'h80);
    check("eq_after_80", cond_true, 1);
    cond_sel = 3'd2; #1;
    check("ne_after_80", cond_true, 0);
    cond_sel = 3'd0; #1;
    check("always_1", cond_true, 1);
    cond_sel = 3'd7; #1;
    check("always_0", cond_true, 0);

    status_valid = 1'b1; ALU_status = 8'b0001_0000; cond_sel = 3'd3;
    step();
    status_valid = 1'b0;
    check("flags_10", flags, 8'h10);
    check("lt_after_10", cond_true, 1);

    status_valid = 1'b1; ALU_status = 8'b0101_0000;
    step();
    status_valid = 1'b0; #1;
    check("lt_after_50", cond_true, 0);
    cond_sel = 3'd6; #1;
    check("vs_after_50", cond_true, 1);
    cond_sel = 3'd5; #1;
    check("cs_after_50", cond_true, 0);
    check("sticky_d0", sticky, 8'hD0);
    check("ovf_count_1", ovf_count, 1);

    // Divide-by-zero wins over overflow and odd
    exc_mask = 3'b111; status_valid = 1'b1; ALU_status = 8'b0100_1100;
    step();
    status_valid = 1'b0;
    check("dz_exc_req", exc_req, 1);
    check("dz_exc_cause", exc_cause, 3);
    check("dz_stall", stall, 1);
    check("dz_flags", flags, 8'h4C);
    step();
    step();
    check("dz_req_held", exc_req, 1);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("dz_drain_req", exc_req, 0);
    check("dz_drain_stall", stall, 1);
    check("dz_drain_cause", exc_cause, 3);
    step();
    check("dz_idle_stall", stall, 0);
    check("dz_idle_cause", exc_cause, 0);

    // Masked overflow only counts; narrow counter saturates
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("clr_sticky", sticky, 0);
    check("clr_ovf_count", ovf_count, 0);
    exc_mask = 3'b000; status_valid = 1'b1; ALU_status = 8'b0100_0000;
    for (int i = 0; i < 5; i++) step();
    status_valid = 1'b0;
    check("mask_no_req", exc_req, 0);
    check("mask_no_stall", stall, 0);
    check("ovf_count_5", ovf_count, 5);
    check("ovf_count2_sat", ovf_count2, 3);

    // Overflow exception; ack on the entry edge is ignored, later samples dropped
    exc_mask = 3'b010; status_valid = 1'b1; ALU_status = 8'b0100_0000; exc_ack = 1'b1;
    step();
    exc_ack = 1'b0; ALU_status = 8'b1000_0000;
    check("ovf_exc_req", exc_req, 1);
    check("ovf_exc_cause", exc_cause, 2);
    exc_mask = 3'b000;
    step();
    step();
    check("drop_flags", flags, 8'h40);
    check("drop_sticky", sticky, 8'h40);
    check("drop_ovf_count", ovf_count, 6);
    check("mask_change_req", exc_req, 1);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    step();
    status_valid = 1'b0;
    check("drop_idle_stall", stall, 0);
    check("drop_flags_after", flags, 8'h40);

    // Simultaneous sticky_clr and sample
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0; status_valid = 1'b1; ALU_status = 8'b1100_0000;
    step();
    check("sticky_c0", sticky, 8'hC0);
    sticky_clr = 1'b1; ALU_status = 8'b0010_0000;
    step();
    sticky_clr = 1'b0; status_valid = 1'b0;
    check("clr_sample_sticky", sticky, 8'h20);
    check("clr_sample_ovf", ovf_count, 0);

    // Reset while a request is outstanding
    exc_mask = 3'b111; status_valid = 1'b1; ALU_status = 8'b0000_1000;
    step();
    status_valid = 1'b0;
    check("odd_exc_req", exc_req, 1);
    check("odd_exc_cause", exc_cause, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_req_exc_req", exc_req, 0);
    check("rst_req_stall", stall, 0);
    check("rst_req_cause", exc_cause, 0);
    check("rst_req_flags", flags, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_status_handler.md
# alu_status_handler

Consumer end of the ALU's 8-bit status bus. Latches the status byte of each retiring ALU operation and accumulates sticky flags. Evaluates branch conditions from the latched flags. Turns overflow, divide-by-zero and odd-result events into a masked exception request with a req/ack handshake to the control unit, stalling the datapath until the request is serviced.

## Interface
- COUNT_W, 8, width of the saturating overflow event counter

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- status_valid  in  1  ALU_status is valid for a retiring operation this cycle
- ALU_status  in  8  [7] zero, [6] overflow, [5] carry, [4] negative, [3] odd result, [2] divide-by-zero, [1:0] unused
- exc_mask  in  3  enable bits: [2] divide-by-zero, [1] overflow, [0] odd result
- cond_sel  in  3  branch condition select
- sticky_clr  in  1  clear sticky flags and ovf_count
- exc_ack  in  1  control unit acknowledges exception
- flags  out  8  last sampled ALU_status, with [1:0] forced to 0
- sticky  out  8  OR-accumulation of sampled ALU_status, with [1:0] forced to 0
- cond_true  out  1  combinational condition result from flags
- exc_req  out  1  exception request, registered
- exc_cause  out  2  0 none, 1 odd, 2 overflow, 3 divide-by-zero
- stall  out  1  registered; high while an exception is outstanding
- ovf_count  out  COUNT_W  saturating count of sampled overflow events

## Operation
- Sample condition: `status_valid & ~stall` at a rising edge.
- On sample:
  - flags <= {ALU_status[7:2], 2'b00}
  - sticky <= sticky | {ALU_status[7:2], 2'b00}
  - ovf_count increments if ALU_status[6] is set, saturating at all-ones. Counting ignores exc_mask.
- When `status_valid` is high while `stall` is high, the status is dropped: no flag, sticky, counter or FSM change.
- `sticky_clr`:
  - Clears sticky and ovf_count.
  - If it coincides with a sample, the sampled values win: sticky <= new status bits, ovf_count <= 0 or 1.
- cond_sel mapping for cond_true:
  - 0 always 1
  - 1 EQ = Z
  - 2 NE = ~Z
  - 3 LT = N ^ V
  - 4 GE = ~(N ^ V)
  - 5 CS = C
  - 6 VS = V
  - 7 always 0
- Exception event: a sample with (ALU_status[2] & exc_mask[2]) | (ALU_status[6] & exc_mask[1]) | (ALU_status[3] & exc_mask[0]).
- Cause priority: divide-by-zero (3) > overflow (2) > odd (1).
- FSM states: IDLE, REQ, DRAIN.
  - IDLE -> REQ on an exception event. exc_req = 1, stall = 1, exc_cause = prioritized cause.
  - REQ holds until an edge with exc_ack = 1, then goes to DRAIN. exc_req = 0, stall = 1, exc_cause held.
  - DRAIN -> IDLE unconditionally. stall = 0, exc_cause = 0.
  - exc_ack outside REQ is ignored.
- exc_mask changes while in REQ do not affect the pending request.

## Timing
- Reset (rst_n low at an edge) values:
  - flags = 0, sticky = 0, ovf_count = 0
  - exc_req = 0, exc_cause = 0, stall = 0
  - FSM = IDLE
- Reset mid-handshake abandons the request, and all outputs return to reset values on the next edge.
- flags, sticky and ovf_count update 1 cycle after the sampling edge. cond_true follows flags in the same cycle.
- exc_req and stall rise 1 cycle after the sampling edge. The next status_valid cycle is therefore already blocked.
- exc_ack sampled high in REQ: exc_req falls next cycle, and stall falls 2 cycles after the ack edge.
- exc_ack high on the same edge that enters REQ is not seen. It must be seen while exc_req = 1.
- Minimum exception turnaround: sample edge, REQ for at least 1 cycle, DRAIN for 1 cycle. stall is high for at least 2 cycles.
- Back-to-back samples without exceptions: one per cycle, no bubbles.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with random inputs -> every output is 0 and ovf_count = 0.
- Flag latch and conditions: sample 8'b1000_0000, then cond_sel = 1 -> cond_true = 1. Sample 8'b0001_0000 with cond_sel = 3 -> cond_true = 1. Sample 8'b0101_0000 -> LT = 0, VS = 1.
- Divide-by-zero priority: exc_mask = 3'b111, sample 8'b0100_1100 -> next cycle exc_req = 1, exc_cause = 3, stall = 1. Ack after 3 cycles -> exc_req = 0 next cycle, stall = 0 one cycle later, exc_cause = 0.
- Masking and counter: exc_mask = 0, sample 8'b0100_0000 five times -> no exc_req, ovf_count = 5. With COUNT_W = 2, the same stimulus -> ovf_count saturates at 3.
- Stall drop: trigger an overflow exception, then hold status_valid = 1 with 8'b1000_0000 during REQ -> flags still show 0x40, sticky unchanged.
- Simultaneous sticky_clr and a sample of 8'b0010_0000 with prior sticky = 0xC0 -> sticky = 0x20. Reset asserted in REQ -> exc_req = 0 and stall = 0 next cycle.
